// File: rtl/alu_pkg.sv
// Opcode encodings and condition-flag bit positions shared by the ALU arbiter
// and its sub-blocks.
package alu_pkg;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_NOT   = 3'b010;
    localparam logic [2:0] OP_PASS1 = 3'b011;
    localparam logic [2:0] OP_PASS2 = 3'b100;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;

    // Codes above PASS2 are reserved and must never reach the ALU.
    function automatic logic is_legal_op(input logic [2:0] op);
        return op <= OP_PASS2;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a last-granted pointer that only advances
// on an actual grant (a grant here is always an accepted transfer).
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    // last = 1 means requester 1 was granted most recently, so 0 is favoured.
    logic last;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (|gnt) begin
            last <= gnt[1];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters and registers the
// result, its owner and the Z/C/N condition flags.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_in1,
    input  logic [WIDTH-1:0] req0_in2,
    input  logic [2:0]       req0_op,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_in1,
    input  logic [WIDTH-1:0] req1_in2,
    input  logic [2:0]       req1_op,
    output logic             req1_ready,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic [2:0]       flags,
    input  logic             flush,
    output logic             illegal
);

    // Handshakes: a transfer happens on a cycle where valid & ready are both 1.
    // ready never depends on the requester's own valid beyond arbitration, and
    // a requester must hold its inputs while valid & !ready.
    logic [1:0]       gnt;
    logic             can_accept;
    logic             accept;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_in1;
    logic [WIDTH-1:0] sel_in2;
    logic             sel_legal;

    assign can_accept = !rst && !flush && (!res_valid || res_ready);

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({req1_valid, req0_valid}),
        .en  (can_accept),
        .gnt (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign accept     = |gnt;

    always_comb begin
        sel_op  = OP_NOP;
        sel_in1 = '0;
        sel_in2 = '0;
        if (gnt[0]) begin
            sel_op  = req0_op;
            sel_in1 = req0_in1;
            sel_in2 = req0_in2;
        end else if (gnt[1]) begin
            sel_op  = req1_op;
            sel_in1 = req1_in1;
            sel_in2 = req1_in2;
        end
    end

    // Reserved opcodes are presented to the ALU as a NOP with zero operands.
    assign sel_legal = is_legal_op(sel_op);
    assign alu_op    = sel_legal ? sel_op  : OP_NOP;
    assign alu_in1   = sel_legal ? sel_in1 : '0;
    assign alu_in2   = sel_legal ? sel_in2 : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= 1'b0;
            flags     <= 3'b000;
            illegal   <= 1'b0;
        end else if (accept) begin
            res_valid <= 1'b1;
            res_data  <= sel_legal ? alu_out : '0;
            res_id    <= gnt[1];
            if (!sel_legal) begin
                illegal <= 1'b1;
            end
            if (sel_op == OP_ADD) begin
                flags[FLAG_Z] <= (alu_out == '0);
                flags[FLAG_N] <= alu_out[WIDTH-1];
                flags[FLAG_C] <= alu_carry;
            end else if (sel_op == OP_NOT) begin
                flags[FLAG_Z] <= (alu_out == '0);
                flags[FLAG_N] <= alu_out[WIDTH-1];
            end
        end else if (flush || (res_valid && res_ready)) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU model attached.
module tb_alu_arbiter;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_in1, req0_in2, req1_in1, req1_in2;
    logic [2:0]   req0_op, req1_op;
    logic         req0_ready, req1_ready;
    logic [W-1:0] alu_in1, alu_in2, alu_out;
    logic [2:0]   alu_op;
    logic         alu_carry;
    logic         res_valid, res_ready, res_id;
    logic [W-1:0] res_data;
    logic [2:0]   flags;
    logic         flush, illegal;

    int checks   = 0;
    int failures = 0;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_in1   (req0_in1),
        .req0_in2   (req0_in2),
        .req0_op    (req0_op),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_in1   (req1_in1),
        .req1_in2   (req1_in2),
        .req1_op    (req1_op),
        .req1_ready (req1_ready),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_op     (alu_op),
        .alu_out    (alu_out),
        .alu_carry  (alu_carry),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .flags      (flags),
        .flush      (flush),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    // Behavioural shared ALU.
    always_comb begin
        alu_out   = '0;
        alu_carry = 1'b0;
        case (alu_op)
            3'b001:  {alu_carry, alu_out} = {1'b0, alu_in1} + {1'b0, alu_in2};
            3'b010:  alu_out = ~alu_in2;
            3'b011:  alu_out = alu_in1;
            3'b100:  alu_out = alu_in2;
            default: alu_out = '0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive0(input logic v, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        req0_valid = v; req0_op = op; req0_in1 = a; req0_in2 = b;
    endtask

    task automatic drive1(input logic v, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        req1_valid = v; req1_op = op; req1_in1 = a; req1_in2 = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; res_ready = 1'b0;
        drive0(1'b1, 3'b001, 16'h0001, 16'h0001);
        drive1(1'b0, 3'b000, 16'h0000, 16'h0000);
        tick();
        // Reset overrides requests.
        check("rst_ready0", {31'b0, req0_ready}, 32'd0);
        tick();
        drive0(1'b0, 3'b000, 16'h0000, 16'h0000);
        rst = 1'b0;
        settle();
        check("rst_res_valid", {31'b0, res_valid}, 32'd0);
        check("rst_res_data", {16'b0, res_data}, 32'h0);
        check("rst_res_id", {31'b0, res_id}, 32'd0);
        check("rst_flags", {29'b0, flags}, 32'd0);
        check("rst_illegal", {31'b0, illegal}, 32'd0);
        check("idle_alu_op", {29'b0, alu_op}, 32'd0);

        // ADD 0x7FFF + 0x0001 from requester 0.
        res_ready = 1'b1;
        drive0(1'b1, 3'b001, 16'h7FFF, 16'h0001);
        settle();
        check("add_ready0", {31'b0, req0_ready}, 32'd1);
        check("add_ready1", {31'b0, req1_ready}, 32'd0);
        check("add_alu_op", {29'b0, alu_op}, 32'd1);
        check("add_alu_in1", {16'b0, alu_in1}, 32'h7FFF);
        tick();
        drive0(1'b0, 3'b000, 16'h0000, 16'h0000);
        settle();
        check("add_res_valid", {31'b0, res_valid}, 32'd1);
        check("add_res_data", {16'b0, res_data}, 32'h8000);
        check("add_res_id", {31'b0, res_id}, 32'd0);
        check("add_flags", {29'b0, flags}, 32'b100);

        // Round-robin alternation from reset.
        do_reset();
        res_ready = 1'b1;
        drive0(1'b1, 3'b011, 16'h000A, 16'h0000);
        drive1(1'b1, 3'b011, 16'h000B, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            settle();
            check("rr_ready0", {31'b0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_ready1", {31'b0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            check("rr_res_id", {31'b0, res_id}, (i % 2 == 1) ? 32'd1 : 32'd0);
            check("rr_res_data", {16'b0, res_data}, (i % 2 == 1) ? 32'h000B : 32'h000A);
        end

        // Backpressure: result held for 3 cycles, then drain and accept together.
        res_ready = 1'b0;
        drive0(1'b1, 3'b001, 16'h0001, 16'h0002);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("bp_ready0", {31'b0, req0_ready}, 32'd0);
            check("bp_ready1", {31'b0, req1_ready}, 32'd0);
            tick();
            check("bp_res_valid", {31'b0, res_valid}, 32'd1);
            check("bp_res_data", {16'b0, res_data}, 32'h000B);
            check("bp_res_id", {31'b0, res_id}, 32'd1);
        end
        res_ready = 1'b1;
        settle();
        check("drain_ready0", {31'b0, req0_ready}, 32'd1);
        tick();
        drive0(1'b0, 3'b000, 16'h0000, 16'h0000);
        drive1(1'b0, 3'b000, 16'h0000, 16'h0000);
        check("drain_res_data", {16'b0, res_data}, 32'h0003);
        check("drain_res_id", {31'b0, res_id}, 32'd0);
        check("drain_flags", {29'b0, flags}, 32'b000);
        tick();
        check("drain_empty", {31'b0, res_valid}, 32'd0);

        // ADD wrapping to zero, then PASS2 leaves flags, then NOT.
        drive1(1'b1, 3'b001, 16'hFFFF, 16'h0001);
        settle();
        check("wrap_ready1", {31'b0, req1_ready}, 32'd1);
        tick();
        check("wrap_res_data", {16'b0, res_data}, 32'h0000);
        check("wrap_res_id", {31'b0, res_id}, 32'd1);
        check("wrap_flags", {29'b0, flags}, 32'b011);
        drive1(1'b1, 3'b100, 16'h0000, 16'h1234);
        tick();
        drive1(1'b0, 3'b000, 16'h0000, 16'h0000);
        check("pass2_res_data", {16'b0, res_data}, 32'h1234);
        check("pass2_flags", {29'b0, flags}, 32'b011);
        drive0(1'b1, 3'b010, 16'h0000, 16'h00FF);
        tick();
        drive0(1'b0, 3'b000, 16'h0000, 16'h0000);
        check("not_res_data", {16'b0, res_data}, 32'hFF00);
        check("not_flags", {29'b0, flags}, 32'b110);

        // Flush with a held result beats a simultaneous drain; pointer unchanged.
        flush = 1'b1;
        drive0(1'b1, 3'b001, 16'h0001, 16'h0001);
        drive1(1'b1, 3'b011, 16'h0055, 16'h0000);
        settle();
        check("flush_ready0", {31'b0, req0_ready}, 32'd0);
        check("flush_ready1", {31'b0, req1_ready}, 32'd0);
        tick();
        flush = 1'b0;
        check("flush_res_valid", {31'b0, res_valid}, 32'd0);
        check("flush_flags", {29'b0, flags}, 32'b110);
        settle();
        check("post_flush_ready1", {31'b0, req1_ready}, 32'd1);
        check("post_flush_ready0", {31'b0, req0_ready}, 32'd0);
        tick();
        drive0(1'b0, 3'b000, 16'h0000, 16'h0000);
        drive1(1'b0, 3'b000, 16'h0000, 16'h0000);
        check("post_flush_data", {16'b0, res_data}, 32'h0055);
        check("post_flush_id", {31'b0, res_id}, 32'd1);

        // Reserved opcode 110.
        drive0(1'b1, 3'b110, 16'h1234, 16'h5678);
        settle();
        check("ill_ready0", {31'b0, req0_ready}, 32'd1);
        check("ill_alu_op", {29'b0, alu_op}, 32'd0);
        tick();
        drive0(1'b0, 3'b000, 16'h0000, 16'h0000);
        check("ill_res_valid", {31'b0, res_valid}, 32'd1);
        check("ill_res_data", {16'b0, res_data}, 32'h0000);
        check("ill_flag", {31'b0, illegal}, 32'd1);
        check("ill_flags", {29'b0, flags}, 32'b110);
        tick();
        tick();
        check("ill_sticky", {31'b0, illegal}, 32'd1);
        do_reset();
        settle();
        check("ill_cleared", {31'b0, illegal}, 32'd0);
        check("flags_cleared", {29'b0, flags}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
